// File: rtl/comparador_pkg.sv
// comparador_pkg: shared types for the bit-serial magnitude comparator.
package comparador_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {RES_EQ, RES_LT, RES_GT} res_e;
  typedef struct packed {
    logic valid;
    res_e kind;
  } result_t;
  // In the sign-bit position the word holding the 1 is the negative one, so the usual sense flips.
  function automatic result_t decide(input logic a_bit, input logic sign_pos);
    return '{valid: 1'b1, kind: (a_bit ^ sign_pos) ? RES_GT : RES_LT};
  endfunction
endpackage

// File: rtl/contador_sat.sv
// contador_sat: saturating up-counter with synchronous clear; clear beats increment.
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/comparador_serial.sv
// comparador_serial: MSB-first bit-serial comparator with early exit, signed/unsigned modes
// and a saturating count of equal results.
module comparador_serial
  import comparador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             clear_count,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [CNT_W-1:0] match_count
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  result_t          res_q, res_d;
  logic             a_msb, b_msb;
  assign a_msb = a_q[WIDTH-1];
  assign b_msb = b_q[WIDTH-1];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        sgn_d   = signed_mode;
        idx_d   = IDX_TOP;
        state_d = SHIFT;
      end
      SHIFT: if (a_msb != b_msb) begin
        res_d   = decide(a_msb, sgn_q && idx_q == IDX_TOP);
        state_d = DONE;
      end else if (idx_q == '0) begin
        res_d   = '{valid: 1'b1, kind: RES_EQ};
        state_d = DONE;
      end else begin
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        idx_d = idx_q - IDX_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign eq   = res_q.valid && res_q.kind == RES_EQ;
  assign lt   = res_q.valid && res_q.kind == RES_LT;
  assign gt   = res_q.valid && res_q.kind == RES_GT;
  contador_sat #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (done && eq),
    .clr  (clear_count),
    .count(match_count)
  );
endmodule
